// File: rtl/jts16_dump_pkg.sv
// Shared types and default widths for the capture-window sequencer.
package jts16_dump_pkg;

   localparam int unsigned FRAMEW_DEF   = 32;
   localparam int unsigned LENW_DEF     = 16;
   localparam int unsigned DL_GUARD_DEF = 1024;
   localparam int unsigned STW          = 3;

   typedef enum logic [STW-1:0] {
      IDLE    = 3'd0,
      WAIT_DL = 3'd1,
      ARMED   = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } dump_st_e;

endpackage

// File: rtl/jts16_dump_edge.sv
// Falling-edge detector: registers the input once and flags a 1 -> 0 transition.
module jts16_dump_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic fall_c
);

   logic d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= 1'b0;
      else        d_q <= d_i;
   end

   assign fall_c = d_q & ~d_i;

endmodule

// File: rtl/jts16_dump_seq.sv
// Capture-window sequencer: counts frames on VS falling edges and opens/closes
// the dump window from a programmed frame number or the end of ROM download.
module jts16_dump_seq
   import jts16_dump_pkg::*;
#(
   parameter int unsigned FRAMEW   = FRAMEW_DEF,
   parameter int unsigned LENW     = LENW_DEF,
   parameter int unsigned DL_GUARD = DL_GUARD_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vs,
   input  logic              downloading,
   input  logic              arm,
   input  logic              abort,
   input  logic              cfg_mode,
   input  logic [FRAMEW-1:0] cfg_start,
   input  logic [LENW-1:0]   cfg_len,
   output logic [FRAMEW-1:0] frame_cnt,
   output logic              dump_en,
   output logic              dump_on,
   output logic              dump_off,
   output logic              done,
   output logic [STW-1:0]    st
);

   localparam int unsigned GW = $clog2(DL_GUARD + 1);

   dump_st_e          state_q, state_d;
   logic [FRAMEW-1:0] frame_cnt_q;
   logic [LENW-1:0]   len_cnt_q;
   logic [GW-1:0]     guard_q;
   logic              mode_l_q;
   logic [FRAMEW-1:0] start_l_q;
   logic [LENW-1:0]   len_l_q;
   logic              dump_en_q, dump_on_q, dump_off_q, done_q;

   logic vs_fall_c, dl_fall_raw_c, dl_fall_c, guard_exp_c;
   logic latch_c, len_inc_c;
   logic dump_en_d, dump_on_d, dump_off_d, done_d;

   jts16_dump_edge u_vs_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (vs),
      .fall_c (vs_fall_c)
   );

   jts16_dump_edge u_dl_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (downloading),
      .fall_c (dl_fall_raw_c)
   );

   assign guard_exp_c = (guard_q == GW'(DL_GUARD));
   assign dl_fall_c   = dl_fall_raw_c & guard_exp_c;

   // Post-reset guard: download edges right after power-up are not trusted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            guard_q <= '0;
      else if (!guard_exp_c) guard_q <= guard_q + GW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         frame_cnt_q <= '0;
      else if (vs_fall_c) frame_cnt_q <= frame_cnt_q + FRAMEW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mode_l_q   <= 1'b0;
         start_l_q  <= '0;
         len_l_q    <= '0;
         len_cnt_q  <= '0;
         dump_en_q  <= 1'b0;
         dump_on_q  <= 1'b0;
         dump_off_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dump_en_q  <= dump_en_d;
         dump_on_q  <= dump_on_d;
         dump_off_q <= dump_off_d;
         done_q     <= done_d;
         if (latch_c) begin
            mode_l_q  <= cfg_mode;
            start_l_q <= cfg_start;
            len_l_q   <= cfg_len;
         end
         if (dump_on_d)      len_cnt_q <= '0;
         else if (len_inc_c) len_cnt_q <= len_cnt_q + LENW'(1);
      end
   end

   // Next state and next registered outputs; abort overrides every other event
   always_comb begin
      state_d   = state_q;
      latch_c   = 1'b0;
      len_inc_c = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (arm) begin
                  latch_c = 1'b1;
                  state_d = cfg_mode ? WAIT_DL : ARMED;
               end
            end
            WAIT_DL: if (dl_fall_c) state_d = CAPTURE;
            ARMED:   if (vs_fall_c && (frame_cnt_q >= start_l_q)) state_d = CAPTURE;
            CAPTURE: begin
               if (vs_fall_c) begin
                  if ((len_l_q != '0) && (len_cnt_q == len_l_q - LENW'(1))) state_d = DONE;
                  else len_inc_c = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      dump_en_d  = (state_d == CAPTURE);
      done_d     = (state_d == DONE);
      dump_on_d  = (state_d == CAPTURE) && (state_q != CAPTURE);
      dump_off_d = (state_q == CAPTURE) && (state_d != CAPTURE);
   end

   assign frame_cnt = frame_cnt_q;
   assign dump_en   = dump_en_q;
   assign dump_on   = dump_on_q;
   assign dump_off  = dump_off_q;
   assign done      = done_q;
   assign st        = state_q;

   // mode_l_q is kept as part of the latched configuration for debug visibility
   logic unused_c;
   assign unused_c = mode_l_q;

endmodule
